fft_stage_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_sb_delay.sv | 49 ++++
 rtl/fft_stage_sequencer.sv | 115 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared constants and side-band type for the 512-point FFT
//            twiddle-multiply + CBFP stage.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int NUM_PARALLEL_PATHS = 16;
    localparam int BLOCK_SIZE         = 512;
    localparam int NUM_CHUNKS         = BLOCK_SIZE / NUM_PARALLEL_PATHS;
    localparam int TW_TABLE_DEPTH     = 64;
    localparam int TW_LAT             = 1;
    localparam int MUL_LAT            = 2;

    // Per-beat control that travels alongside the datapath delay line.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } fft_sb_t;

endpackage
`default_nettype wire

// File: rtl/fft_sb_delay.sv
`default_nettype none
// ============================================================================
// Module   : fft_sb_delay
// Brief    : Fixed-depth shift register of side-band words with a
//            synchronous clear; exposes every stage's valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module fft_sb_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  fft_sb_t          d,
    output fft_sb_t          q,
    output logic [DEPTH-1:0] valid_vec
);

    fft_sb_t [DEPTH-1:0] r_stage;
    fft_sb_t [DEPTH-1:0] w_next;

    // Next contents of the line: new word enters stage 0, the rest shift up.
    if (DEPTH == 1) begin : g_single
        assign w_next = d;
    end else begin : g_chain
        assign w_next = {r_stage[DEPTH-2:0], d};
    end

    // Shift every cycle; a clear empties the whole line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else if (clr) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_next;
        end
    end

    assign q = r_stage[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        assign valid_vec[i] = r_stage[i].valid;
    end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Brief    : Beat scheduler for the twiddle-multiply + CBFP stage. Counts
//            beats into blocks, drives the twiddle ROM base address and
//            produces latency-aligned multiplier/CBFP enables and markers.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int NUM_PARALLEL_PATHS = fft_pkg::NUM_PARALLEL_PATHS,
    parameter int BLOCK_SIZE         = fft_pkg::BLOCK_SIZE,
    parameter int TW_TABLE_DEPTH     = fft_pkg::TW_TABLE_DEPTH,
    parameter int TW_LAT             = fft_pkg::TW_LAT,
    parameter int MUL_LAT            = fft_pkg::MUL_LAT
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    input  logic                                              abort,
    output logic [$clog2(BLOCK_SIZE/NUM_PARALLEL_PATHS)-1:0]  chunk_idx,
    output logic [$clog2(TW_TABLE_DEPTH)-1:0]                 tw_base,
    output logic                                              tw_en,
    output logic                                              mul_en,
    output logic                                              cbfp_en,
    output logic                                              cbfp_first,
    output logic                                              cbfp_last,
    output logic                                              blk_done,
    output logic [15:0]                                       blk_cnt,
    output logic                                              busy
);

    localparam int c_NUM_CHUNKS = BLOCK_SIZE / NUM_PARALLEL_PATHS;
    localparam int c_CNT_W      = $clog2(c_NUM_CHUNKS);
    localparam int c_TW_W       = $clog2(TW_TABLE_DEPTH);
    localparam int c_NPP_W      = $clog2(NUM_PARALLEL_PATHS);
    localparam int c_DEPTH      = TW_LAT + MUL_LAT;
    localparam logic [c_CNT_W-1:0] c_LAST_CHUNK = c_CNT_W'(c_NUM_CHUNKS - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_blk_done;
    logic [15:0]        r_blk_cnt;
    fft_sb_t            w_sb_in;
    fft_sb_t            w_sb_out;
    logic [c_DEPTH-1:0] w_valid_vec;
    logic               w_blk_end;

    // Beat counter: advances per accepted beat, wraps with no idle cycle; abort wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            if (r_cnt == c_LAST_CHUNK) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign chunk_idx = r_cnt;
    // Held low during reset so every output reads 0 while rst is asserted.
    assign tw_en     = in_valid && !rst;

    // ROM base is cnt*paths mod depth: with power-of-two sizes that is the low
    // count bits shifted up by log2(paths), so no multiplier is needed.
    if (c_TW_W <= c_NPP_W) begin : g_tw_zero
        assign tw_base = '0;
    end else begin : g_tw_slice
        assign tw_base = {r_cnt[c_TW_W-c_NPP_W-1:0], {c_NPP_W{1'b0}}};
    end

    assign w_sb_in.valid = in_valid;
    assign w_sb_in.first = in_valid && (r_cnt == '0);
    assign w_sb_in.last  = in_valid && (r_cnt == c_LAST_CHUNK);

    fft_sb_delay #(
        .DEPTH (c_DEPTH)
    ) u_sb_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .d         (w_sb_in),
        .q         (w_sb_out),
        .valid_vec (w_valid_vec)
    );

    assign mul_en     = w_valid_vec[TW_LAT-1];
    assign cbfp_en    = w_sb_out.valid;
    assign cbfp_first = w_sb_out.first;
    assign cbfp_last  = w_sb_out.last;
    assign w_blk_end  = w_sb_out.valid && w_sb_out.last;

    // Block-complete pulse and counter, one cycle after the last beat reaches CBFP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_done <= 1'b0;
            r_blk_cnt  <= '0;
        end else begin
            r_blk_done <= w_blk_end;
            if (w_blk_end) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign blk_done = r_blk_done;
    assign blk_cnt  = r_blk_cnt;
    assign busy     = (r_cnt != '0) || (|w_valid_vec);

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_sequencer
// Brief    : Directed, scoreboard-based bench for fft_stage_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

    localparam int NCH = 32;   // beats per block
    localparam int TWL = 1;    // ROM latency
    localparam int LAT = 3;    // ROM + multiplier latency

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  chunk_idx;
    logic [5:0]  tw_base;
    logic        tw_en, mul_en, cbfp_en, cbfp_first, cbfp_last, blk_done, busy;
    logic [15:0] blk_cnt;

    fft_stage_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .abort      (abort),
        .chunk_idx  (chunk_idx),
        .tw_base    (tw_base),
        .tw_en      (tw_en),
        .mul_en     (mul_en),
        .cbfp_en    (cbfp_en),
        .cbfp_first (cbfp_first),
        .cbfp_last  (cbfp_last),
        .blk_done   (blk_done),
        .blk_cnt    (blk_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit first;
        bit last;
    } ent_t;

    ent_t cq[$];   // expected CBFP beats (due cycle + markers)
    int   mq[$];   // expected mul_en cycles
    int   bq[$];   // expected blk_done cycles

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_cnt = 0;
    int m_blk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".chunk_idx"}, 32'(chunk_idx), 0);
        chk({tag, ".tw_base"},   32'(tw_base), 0);
        chk({tag, ".tw_en"},     32'(tw_en), 0);
        chk({tag, ".mul_en"},    32'(mul_en), 0);
        chk({tag, ".cbfp_en"},   32'(cbfp_en), 0);
        chk({tag, ".cbfp_first"},32'(cbfp_first), 0);
        chk({tag, ".cbfp_last"}, 32'(cbfp_last), 0);
        chk({tag, ".blk_done"},  32'(blk_done), 0);
        chk({tag, ".blk_cnt"},   32'(blk_cnt), 0);
        chk({tag, ".busy"},      32'(busy), 0);
    endtask

    // One clock cycle: drive inputs, compare against the scoreboard, advance.
    task automatic step(input logic v, input logic a);
        bit   e_mul, e_cbfp, e_first, e_last, e_done, e_busy;
        ent_t ent;
        e_first = 1'b0;
        e_last  = 1'b0;
        in_valid = v;
        abort    = a;
        #2;
        chk("chunk_idx", 32'(chunk_idx), m_cnt);
        chk("tw_base",   32'(tw_base), (m_cnt * 16) % 64);
        chk("tw_en",     32'(tw_en), 32'(v));

        e_busy = (m_cnt != 0) || (cq.size() != 0);
        e_mul  = (mq.size() != 0) && (mq[0] == cyc);
        if (e_mul) void'(mq.pop_front());
        e_cbfp = (cq.size() != 0) && (cq[0].due == cyc);
        if (e_cbfp) begin
            ent     = cq.pop_front();
            e_first = ent.first;
            e_last  = ent.last;
            if (ent.last) bq.push_back(cyc + 1);
        end
        e_done = (bq.size() != 0) && (bq[0] == cyc);
        if (e_done) begin
            void'(bq.pop_front());
            m_blk = (m_blk + 1) % 65536;
        end

        chk("mul_en",     32'(mul_en), 32'(e_mul));
        chk("cbfp_en",    32'(cbfp_en), 32'(e_cbfp));
        chk("cbfp_first", 32'(cbfp_first), 32'(e_first));
        chk("cbfp_last",  32'(cbfp_last), 32'(e_last));
        chk("blk_done",   32'(blk_done), 32'(e_done));
        chk("blk_cnt",    32'(blk_cnt), m_blk);
        chk("busy",       32'(busy), 32'(e_busy));

        @(posedge clk);
        #1;
        if (a) begin
            m_cnt = 0;
            cq.delete();
            mq.delete();
        end else if (v) begin
            mq.push_back(cyc + TWL);
            cq.push_back('{cyc + LAT, m_cnt == 0, m_cnt == NCH - 1});
            m_cnt = (m_cnt + 1) % NCH;
        end
        cyc++;
    endtask

    // Reset pulse spanning one clock edge; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        abort    = 1'b0;
        rst      = 1'b1;
        #2;
        chk_all_zero(tag);
        cq.delete();
        mq.delete();
        bq.delete();
        m_cnt = 0;
        m_blk = 0;
        @(posedge clk);
        #1;
        chk_all_zero({tag, "_held"});
        rst = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        // Power-on reset: rising edge on rst before the first clock edge.
        #1;
        do_reset("por");

        // One block of 32 consecutive beats.
        beats(32);
        idle(6);
        chk("one_block_blk_cnt", 32'(blk_cnt), 1);

        // Two blocks back-to-back: last/first markers on adjacent cycles.
        do_reset("rst_b2b");
        beats(64);
        idle(6);
        chk("b2b_blk_cnt", 32'(blk_cnt), 2);

        // Gaps: one idle cycle after every 5th beat.
        do_reset("rst_gap");
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            if (i % 5 == 4) step(1'b0, 1'b0);
        end
        idle(6);
        chk("gap_blk_cnt", 32'(blk_cnt), 1);

        // Abort after 10 beats, then a full block.
        do_reset("rst_abort");
        beats(10);
        step(1'b0, 1'b1);
        chk("abort_chunk_idx", 32'(chunk_idx), 0);
        chk("abort_blk_cnt", 32'(blk_cnt), 0);
        beats(31);
        idle(2);
        chk("abort_partial_blk_cnt", 32'(blk_cnt), 0);
        beats(1);
        idle(6);
        chk("abort_new_blk_cnt", 32'(blk_cnt), 1);

        // Abort and in_valid together: that beat is dropped.
        beats(5);
        step(1'b1, 1'b1);
        idle(5);
        chk("abort_same_cycle_busy", 32'(busy), 0);
        beats(32);
        idle(6);
        chk("abort_same_cycle_blk_cnt", 32'(blk_cnt), 2);

        // Reset in the middle of a block (beat 20).
        beats(20);
        do_reset("rst_mid");
        chk("rst_mid_busy", 32'(busy), 0);
        beats(32);
        idle(6);
        chk("rst_mid_blk_cnt", 32'(blk_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
